// File: rtl/prach_uplane_packer.sv
// Packs PRACH FFT samples (32b {I,Q}) into 128b U-plane beats, one packet per symbol, via an FWFT FIFO.
// Optional packet/drop statistics counters are built when PRACH_PACKER_STATS_EN is defined.
module prach_uplane_packer #(
  parameter int SAMPLES_PER_SYM = 840,
  parameter int FIFO_DEPTH      = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [15:0]          din_dr,
  input  logic signed [15:0]          din_di,
  input  logic                        din_dv,
  input  logic                        sync_in,
  output logic [127:0]                dout_data,
  output logic                        dout_valid,
  output logic                        dout_sop,
  output logic                        dout_eop,
  input  logic                        dout_ready,
  output logic                        err_overflow,
  output logic                        err_truncated,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 stat_pkt_cnt,
  output logic [15:0]                 stat_drop_cnt
);

  localparam int BEATS = SAMPLES_PER_SYM / 4;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int OW    = LW + 1;
  localparam int CW    = $clog2(SAMPLES_PER_SYM);

  typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    slot;
  logic [31:0]   smp;
  logic [31:0]   acc_q [3];
  logic          stg_vld_q, stg_sop_q, stg_eop_q;
  logic [127:0]  stg_data_q;
  logic          err_ovf_q, err_trn_q;
  logic          fire, early, retag, trunc_beat, fits, take, complete, last;
  logic [OW-1:0] occ;
  logic [127:0]  full_beat, part_beat;

  logic [129:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] mem_cnt_q, mem_cnt_d, level_q, level_d;
  logic          push, pop, load, push_eop;
  logic [127:0]  out_data_q;
  logic          out_vld_q, out_sop_q, out_eop_q;

  assign slot       = cnt_q[1:0];
  assign smp        = {din_dr, din_di};
  assign fire       = din_dv & sync_in;
  assign early      = fire & (state_q == PACK);
  // An early sync right after a completed beat re-tags that still-staged beat instead of adding one
  assign retag      = early & (slot == 2'd0) & stg_vld_q;
  assign trunc_beat = early & ~retag;
  assign occ        = OW'(level_q) + OW'(stg_vld_q) + OW'(trunc_beat);
  assign fits       = (occ + OW'(BEATS)) < OW'(FIFO_DEPTH);
  assign take       = din_dv & ~sync_in & (state_q == PACK);
  assign complete   = take & (slot == 2'd3);
  assign last       = take & (cnt_q == CW'(SAMPLES_PER_SYM - 1));
  assign full_beat  = {acc_q[0], acc_q[1], acc_q[2], smp};
  assign part_beat  = {(slot > 2'd0) ? acc_q[0] : 32'd0,
                       (slot > 2'd1) ? acc_q[1] : 32'd0,
                       (slot > 2'd2) ? acc_q[2] : 32'd0,
                       32'd0};

  // Stage 0: sample capture, packet FSM, beat staging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stg_vld_q <= 1'b0;
      stg_sop_q <= 1'b0;
      stg_eop_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_trn_q <= 1'b0;
    end else begin
      stg_vld_q <= complete | trunc_beat;
      stg_sop_q <= (cnt_q < CW'(4));
      stg_eop_q <= last | trunc_beat;
      err_ovf_q <= fire & ~fits;
      err_trn_q <= early;
      if (fire) begin
        state_q <= fits ? PACK : DROP;
        cnt_q   <= fits ? CW'(1) : '0;
      end else if (take) begin
        if (last) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take && (slot != 2'd3)) acc_q[slot] <= smp;
    else if (fire && fits)      acc_q[0]    <= smp;
    if (complete)        stg_data_q <= full_beat;
    else if (trunc_beat) stg_data_q <= part_beat;
  end

  // Stage 1: FIFO write; stage 2: FWFT output register
  assign push      = stg_vld_q;
  assign push_eop  = stg_eop_q | retag;
  assign pop       = out_vld_q & dout_ready;
  assign load      = (mem_cnt_q != '0) & (~out_vld_q | dout_ready);
  assign mem_cnt_d = mem_cnt_q + LW'(push) - LW'(load);
  assign level_d   = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {stg_sop_q, push_eop, stg_data_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      level_q    <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (load) begin
        rptr_q <= rptr_q + 1'b1;
        {out_sop_q, out_eop_q, out_data_q} <= mem[rptr_q];
      end
      out_vld_q <= load | (out_vld_q & ~dout_ready);
      mem_cnt_q <= mem_cnt_d;
      level_q   <= level_d;
    end
  end

  assign dout_data     = out_data_q;
  assign dout_valid    = out_vld_q;
  assign dout_sop      = out_sop_q;
  assign dout_eop      = out_eop_q;
  assign fifo_level    = level_q;
  assign err_overflow  = err_ovf_q;
  assign err_truncated = err_trn_q;

`ifdef PRACH_PACKER_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && push_eop) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (fire && !fits && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_prach_uplane_packer.sv
// Scoreboard bench for prach_uplane_packer: a packet-level model queues expected beats, a monitor pops them.
module tb_prach_uplane_packer;
  localparam int SPS   = 840;
  localparam int DEPTH = 512;
  localparam int BEATS = SPS / 4;
`ifdef PRACH_PACKER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] din_dr = '0;
  logic signed [15:0] din_di = '0;
  logic               din_dv = 1'b0;
  logic               sync_in = 1'b0;
  logic [127:0]       dout_data;
  logic               dout_valid, dout_sop, dout_eop;
  logic               dout_ready = 1'b0;
  logic               err_overflow, err_truncated;
  logic [9:0]         fifo_level;
  logic [31:0]        stat_pkt_cnt;
  logic [15:0]        stat_drop_cnt;

  prach_uplane_packer #(.SAMPLES_PER_SYM(SPS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_data(dout_data), .dout_valid(dout_valid), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_ready(dout_ready), .err_overflow(err_overflow),
    .err_truncated(err_truncated), .fifo_level(fifo_level), .stat_pkt_cnt(stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0: hold low, 1: hold high, 2: random each cycle
  int rdy_mode = 1;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: expected beats {sop, eop, data[127:0]} in output order
  logic [129:0] sb_q[$];
  logic [31:0]  m_acc[$];
  bit           m_pack = 1'b0;
  bit           m_prev_done = 1'b0;
  int           m_n = 0, m_beat = 0;
  int           ovf_exp = 0, trn_exp = 0, pkt_exp = 0, drop_exp = 0;
  int           ovf_seen = 0, trn_seen = 0;
  int           t0 = 0;
  bit           lat_armed = 1'b0;

  task automatic push_beat(input bit sop, input bit eop);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < m_acc.size(); k++) d[127-32*k -: 32] = m_acc[k];
    sb_q.push_back({sop, eop, d});
    m_acc.delete();
    if (eop) pkt_exp++;
  endtask

  task automatic put(input logic [31:0] s, input bit sync);
    logic [129:0] tmp;
    bit done;
    done = 1'b0;
    if (sync) begin
      if (m_pack) begin
        trn_exp++;
        if (m_acc.size() != 0) push_beat(m_beat == 0, 1'b1);
        else if (m_prev_done) begin
          tmp = sb_q.pop_back();
          tmp[128] = 1'b1;
          sb_q.push_back(tmp);
          pkt_exp++;
        end else push_beat(1'b0, 1'b1);
      end
      if (sb_q.size() + BEATS < DEPTH) begin
        m_pack = 1'b1;
        m_n    = 0;
        m_beat = 0;
      end else begin
        m_pack = 1'b0;
        ovf_exp++;
        if (drop_exp < 65535) drop_exp++;
      end
    end
    if (m_pack) begin
      m_acc.push_back(s);
      m_n++;
      if (m_acc.size() == 4) begin
        push_beat(m_beat == 0, m_n == SPS);
        m_beat++;
        done = 1'b1;
        if (m_n == SPS) m_pack = 1'b0;
      end
    end
    m_prev_done = done;
    @(posedge clk);
    #1;
    din_dv  = 1'b1;
    sync_in = sync;
    {din_dr, din_di} = s;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      m_prev_done = 1'b0;
      @(posedge clk);
      #1;
      din_dv  = 1'b0;
      sync_in = 1'($urandom_range(0, 1));
      {din_dr, din_di} = $urandom;
    end
  endtask

  function automatic logic [31:0] ramp(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v, -v};
  endfunction

  // mode 0: ramp samples, 1: random samples; spacing = cycles per sample
  task automatic send_pkt(input int n, input bit rnd, input int spacing);
    for (int i = 0; i < n; i++) begin
      put(rnd ? 32'($urandom) : ramp(i), i == 0);
      if (spacing > 1) idle(spacing - 1);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || dout_valid) && w < budget) begin
      @(posedge clk);
      w++;
    end
    #2;
    chk({name, "_remaining"}, 131'(sb_q.size()), 131'(0));
    chk({name, "_level"}, 131'(fifo_level), 131'(0));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_acc.delete();
    m_pack = 1'b0;
    m_prev_done = 1'b0;
    pkt_exp = 0;
    drop_exp = 0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_valid"}, 131'(dout_valid), 131'(0));
    chk({name, "_sopeop"}, 131'({dout_sop, dout_eop}), 131'(0));
    chk({name, "_data"}, 131'(dout_data), 131'(0));
    chk({name, "_level"}, 131'(fifo_level), 131'(0));
    chk({name, "_errs"}, 131'({err_overflow, err_truncated}), 131'(0));
    chk({name, "_stats"}, 131'({stat_pkt_cnt, stat_drop_cnt}), 131'(0));
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks hold-while-stalled
  logic [130:0] held;
  bit           stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) stall = 1'b0;
    else begin
      if (err_overflow)  ovf_seen++;
      if (err_truncated) trn_seen++;
      if (lat_armed && dout_valid) begin
        chk("first_valid_latency", 131'(cyc - t0 - 1), 131'(5));
        lat_armed = 1'b0;
      end
      if (stall) chk("stall_hold", {dout_valid, dout_sop, dout_eop, dout_data}, held);
      if (dout_valid && dout_ready) begin
        if (sb_q.size() == 0) chk("unexpected_beat", 131'(dout_valid), 131'(0));
        else chk("beat", {1'b0, dout_sop, dout_eop, dout_data}, {1'b0, sb_q.pop_front()});
      end
      stall = dout_valid && !dout_ready;
      held  = {1'b1, dout_sop, dout_eop, dout_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_quiet("reset");
    rst_n = 1'b1;
    idle(2);

    // Samples without sync in IDLE are ignored
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) put($urandom, 1'b0);
    idle(6);
    chk("idle_ignore_valid", 131'(dout_valid), 131'(0));
    chk("idle_ignore_level", 131'(fifo_level), 131'(0));

    // Back-to-back ramp symbol, sink always ready
    for (int i = 0; i < SPS; i++) begin
      put(ramp(i), i == 0);
      if (i == 0) begin
        t0 = cyc;
        lat_armed = 1'b1;
      end
    end
    idle(1);
    wait_drain("ramp_b2b", 400);

    // Same symbol, one sample in three, sink ready toggling
    rdy_mode = 2;
    send_pkt(SPS, 1'b0, 3);
    idle(1);
    wait_drain("ramp_gapped", 1000);

    // Truncations: partial beat, re-tag of staged beat, zero beat after a gap
    rdy_mode = 1;
    send_pkt(402, 1'b1, 1);
    send_pkt(400, 1'b1, 1);
    send_pkt(400, 1'b1, 1);
    idle(3);
    send_pkt(SPS, 1'b1, 1);
    idle(1);
    wait_drain("truncation", 600);
    chk("truncated_pulses", 131'(trn_seen), 131'(trn_exp));

    // Sink stalled: two symbols fit, the third is dropped
    rdy_mode = 0;
    idle(2);
    for (int p = 0; p < 3; p++) send_pkt(SPS, 1'b1, 1);
    idle(10);
    chk("overflow_level", 131'(fifo_level), 131'(sb_q.size()));
    chk("overflow_valid_held", 131'(dout_valid), 131'(1));
    chk("overflow_pulses", 131'(ovf_seen), 131'(ovf_exp));
    chk("overflow_drop_cnt", 131'(stat_drop_cnt), 131'(STATS_ON ? drop_exp : 0));
    rdy_mode = 1;
    wait_drain("overflow", 1200);

    // Reset in the middle of a packet
    send_pkt(202, 1'b1, 1);
    @(posedge clk);
    #1;
    din_dv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midpkt_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    // Five clean symbols after reset
    for (int p = 0; p < 5; p++) send_pkt(SPS, 1'b1, 1);
    idle(1);
    wait_drain("post_reset", 600);
    chk("stat_pkt_cnt", 131'(stat_pkt_cnt), 131'(STATS_ON ? pkt_exp : 0));
    chk("stat_drop_cnt", 131'(stat_drop_cnt), 131'(STATS_ON ? drop_exp : 0));
    chk("overflow_pulses_final", 131'(ovf_seen), 131'(ovf_exp));
    chk("truncated_pulses_final", 131'(trn_seen), 131'(trn_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
